// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage constants and types: datapath widths, PC step, reset PC,
// the NOP encoding and the {pc, instr} entry carried through the output buffer.
package instr_fetch_pkg;

   localparam int XLEN    = 32;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(PC_STEP);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and
// the {instr, pc} valid/ready handshake towards decode.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic            imem_re;
   logic [XLEN-1:0] imem_a;
   logic [ILEN-1:0] imem_rd;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            if_valid;
   logic            if_ready;
   logic [ILEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;

   modport master (
      output imem_re, imem_a, if_valid, if_instr, if_pc,
      input  imem_rd, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_re, imem_a, if_valid, if_instr, if_pc,
      output imem_rd, redirect_valid, redirect_pc, if_ready
   );

endinterface

// File: rtl/instr_fetch_buf.sv
// fetch_buf: synchronous DEPTH-entry FIFO of {pc, instr} with push, pop and
// flush; the head is read straight out of the storage registers.
module fetch_buf
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output fetch_entry_t               head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem_q [DEPTH];
   fetch_entry_t   mem_d [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // flush wins over a same-cycle push/pop so nothing stale survives a redirect
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && push && !pop) begin
         assert (count_q < CW'(DEPTH));
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-gated issue to a 1-cycle instruction memory, redirect
// flush and the output buffer. IF_PERF_EN adds fetch/stall performance counters.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_if.master      fif
`ifdef IF_PERF_EN
   ,
   output logic [31:0]        perf_fetch_cnt,
   output logic [31:0]        perf_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tag_pc_q, tag_pc_d;
   logic            pending_q, pending_d;

   logic [CW-1:0]   count;
   fetch_entry_t    head;
   fetch_entry_t    push_data;
   logic            issue, push, pop, flush, buf_valid;

   always_comb begin
      flush     = fif.redirect_valid;
      buf_valid = (count != '0) && !rst;
      // an in-flight read already owns a slot, so it counts against the credit
      issue     = !rst && !fif.redirect_valid
                  && (({{(CW-1){1'b0}}, pending_q} + count) < CW'(DEPTH));
      push      = pending_q && !flush;
      pop       = buf_valid && fif.if_ready && !flush;
      push_data = '{pc: tag_pc_q, instr: fif.imem_rd};

      pc_d      = pc_q;
      tag_pc_d  = tag_pc_q;
      pending_d = issue;
      if (flush) begin
         pc_d = fif.redirect_pc;
      end else if (issue) begin
         pc_d     = pc_next(pc_q);
         tag_pc_d = pc_q;
      end

      fif.imem_re  = issue;
      fif.imem_a   = pc_q;
      fif.if_valid = buf_valid;
      fif.if_instr = buf_valid ? head.instr : NOP_INSTR;
      fif.if_pc    = head.pc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         tag_pc_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         tag_pc_q  <= tag_pc_d;
         pending_q <= pending_d;
      end
   end

   fetch_buf #(.DEPTH(DEPTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .count     (count),
      .head      (head)
   );

`ifdef IF_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(pop);
      perf_stall_d = perf_stall_q + 32'(buf_valid && !fif.if_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: startup, backpressure, redirects, reset,
// PC wrap (second instance) and, with IF_PERF_EN, the performance counters.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rst_w;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] exp_pc;

   instr_fetch_if fi();
   instr_fetch_if fw();

`ifdef IF_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_stall_cnt;
   logic [31:0] perf_fetch_w, perf_stall_w;
`endif

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .fif (fi)
`ifdef IF_PERF_EN
      , .perf_fetch_cnt (perf_fetch_cnt)
      , .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
      .clk (clk),
      .rst (rst_w),
      .fif (fw)
`ifdef IF_PERF_EN
      , .perf_fetch_cnt (perf_fetch_w)
      , .perf_stall_cnt (perf_stall_w)
`endif
   );

   // instruction memory: word at byte address a holds a>>2
   always_ff @(posedge clk) begin
      if (fi.imem_re) fi.imem_rd <= {2'b00, fi.imem_a[31:2]};
      if (fw.imem_re) fw.imem_rd <= {2'b00, fw.imem_a[31:2]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_w = 1'b1;
      fi.redirect_valid = 1'b0; fi.redirect_pc = '0; fi.if_ready = 1'b1;
      fw.redirect_valid = 1'b0; fw.redirect_pc = '0; fw.if_ready = 1'b1;
      tick(); tick(); settle();
      n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL reset_imem_re: got %b want 0", fi.imem_re); end
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %b want 0", fi.if_valid); end
   endtask

   task automatic test_startup();
      int acc = 0;
      tick(); rst = 1'b0; settle();
      n_cmp++; if (fi.imem_re !== 1'b1) begin n_bad++; $display("FAIL start_re_c0: got %b want 1", fi.imem_re); end
      n_cmp++; if (fi.imem_a !== 32'h0) begin n_bad++; $display("FAIL start_a_c0: got %h want 00000000", fi.imem_a); end
      tick(); settle();
      n_cmp++; if (fi.imem_a !== 32'h4) begin n_bad++; $display("FAIL start_a_c1: got %h want 00000004", fi.imem_a); end
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL start_valid_c1: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1) begin n_bad++; $display("FAIL start_valid_c2: got %b want 1", fi.if_valid); end
      n_cmp++; if (fi.if_pc !== 32'h0) begin n_bad++; $display("FAIL start_pc_c2: got %h want 00000000", fi.if_pc); end
      n_cmp++; if (fi.if_instr !== 32'h0) begin n_bad++; $display("FAIL start_instr_c2: got %h want 00000000", fi.if_instr); end
      exp_pc = 32'h4;
      repeat (12) begin
         tick(); settle();
         if (fi.if_valid) begin
            n_cmp++; if (fi.if_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc: got %h want %h", fi.if_pc, exp_pc); end
            n_cmp++; if (fi.if_instr !== (exp_pc >> 2)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", fi.if_instr, exp_pc >> 2); end
            exp_pc += 32'd4;
            acc++;
         end
      end
      n_cmp++; if (acc < 6) begin n_bad++; $display("FAIL stream_count: got %0d want >=6", acc); end
   endtask

   task automatic test_backpressure();
      int k = 0;
      int acc = 0;
      logic [31:0] head;
      tick(); fi.if_ready = 1'b0; settle();
      while (!fi.if_valid && k < 10) begin tick(); settle(); k++; end
      n_cmp++; if (fi.if_valid !== 1'b1) begin n_bad++; $display("FAIL bp_wait_valid: got %b want 1", fi.if_valid); end
      head = fi.if_pc;
      n_cmp++; if (head !== exp_pc) begin n_bad++; $display("FAIL bp_head_pc: got %h want %h", head, exp_pc); end
      for (int i = 0; i < 5; i++) begin
         tick(); settle();
         n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== head) begin
            n_bad++; $display("FAIL bp_hold: got valid=%b pc=%h want valid=1 pc=%h", fi.if_valid, fi.if_pc, head);
         end
         if (i >= 3) begin
            n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL bp_imem_re: got %b want 0", fi.imem_re); end
         end
      end
      tick(); fi.if_ready = 1'b1; settle();
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin tick(); settle(); end
         if (fi.if_valid) begin
            n_cmp++; if (fi.if_pc !== exp_pc) begin n_bad++; $display("FAIL bp_resume_pc: got %h want %h", fi.if_pc, exp_pc); end
            exp_pc += 32'd4;
            acc++;
         end
      end
      n_cmp++; if (acc < 6) begin n_bad++; $display("FAIL bp_resume_count: got %0d want >=6", acc); end
   endtask

   task automatic test_redirect_full();
      tick(); fi.if_ready = 1'b0; settle();
      repeat (4) begin tick(); settle(); end
      n_cmp++; if (fi.imem_re !== 1'b0 || fi.if_valid !== 1'b1) begin
         n_bad++; $display("FAIL rf_full_pre: got re=%b valid=%b want re=0 valid=1", fi.imem_re, fi.if_valid);
      end
      tick(); fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h100; fi.if_ready = 1'b1; settle();
      n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL rf_re_r: got %b want 0", fi.imem_re); end
      tick(); fi.redirect_valid = 1'b0; settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL rf_valid_r1: got %b want 0", fi.if_valid); end
      n_cmp++; if (fi.imem_re !== 1'b1 || fi.imem_a !== 32'h100) begin
         n_bad++; $display("FAIL rf_issue_r1: got re=%b a=%h want re=1 a=00000100", fi.imem_re, fi.imem_a);
      end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL rf_valid_r2: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h100) begin
         n_bad++; $display("FAIL rf_out_r3: got valid=%b pc=%h want valid=1 pc=00000100", fi.if_valid, fi.if_pc);
      end
      n_cmp++; if (fi.if_instr !== 32'h40) begin n_bad++; $display("FAIL rf_instr_r3: got %h want 00000040", fi.if_instr); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h104) begin
         n_bad++; $display("FAIL rf_out_r4: got valid=%b pc=%h want valid=1 pc=00000104", fi.if_valid, fi.if_pc);
      end
   endtask

   task automatic test_redirect_pending();
      int k = 0;
      tick(); settle();
      while (!fi.imem_re && k < 10) begin tick(); settle(); k++; end
      n_cmp++; if (fi.imem_re !== 1'b1) begin n_bad++; $display("FAIL rp_find_issue: got %b want 1", fi.imem_re); end
      tick(); fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h180; settle();
      n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL rp_re_r: got %b want 0", fi.imem_re); end
      tick(); fi.redirect_valid = 1'b0; settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL rp_valid_r1: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL rp_valid_r2: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h180) begin
         n_bad++; $display("FAIL rp_out_r3: got valid=%b pc=%h want valid=1 pc=00000180", fi.if_valid, fi.if_pc);
      end
   endtask

   task automatic test_back_to_back();
      tick(); fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h200; settle();
      n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL b2b_re_1: got %b want 0", fi.imem_re); end
      tick(); fi.redirect_pc = 32'h300; settle();
      n_cmp++; if (fi.imem_re !== 1'b0) begin n_bad++; $display("FAIL b2b_re_2: got %b want 0", fi.imem_re); end
      tick(); fi.redirect_valid = 1'b0; settle();
      n_cmp++; if (fi.imem_re !== 1'b1 || fi.imem_a !== 32'h300) begin
         n_bad++; $display("FAIL b2b_issue: got re=%b a=%h want re=1 a=00000300", fi.imem_re, fi.imem_a);
      end
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_r1: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_r2: got %b want 0", fi.if_valid); end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h300) begin
         n_bad++; $display("FAIL b2b_out_r3: got valid=%b pc=%h want valid=1 pc=00000300", fi.if_valid, fi.if_pc);
      end
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h304) begin
         n_bad++; $display("FAIL b2b_out_r4: got valid=%b pc=%h want valid=1 pc=00000304", fi.if_valid, fi.if_pc);
      end
   endtask

   task automatic test_reset_midstream();
      int k = 0;
      tick(); settle();
      while (!fi.if_valid && k < 10) begin tick(); settle(); k++; end
      n_cmp++; if (fi.if_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid: got %b want 1", fi.if_valid); end
      tick(); rst = 1'b1; settle();
      n_cmp++; if (fi.if_valid !== 1'b0 || fi.imem_re !== 1'b0) begin
         n_bad++; $display("FAIL rm_during_rst: got valid=%b re=%b want valid=0 re=0", fi.if_valid, fi.imem_re);
      end
      tick(); rst = 1'b0; settle();
      n_cmp++; if (fi.if_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid_after: got %b want 0", fi.if_valid); end
      n_cmp++; if (fi.imem_re !== 1'b1 || fi.imem_a !== 32'h0) begin
         n_bad++; $display("FAIL rm_restart: got re=%b a=%h want re=1 a=00000000", fi.imem_re, fi.imem_a);
      end
      tick(); settle();
      tick(); settle();
      n_cmp++; if (fi.if_valid !== 1'b1 || fi.if_pc !== 32'h0) begin
         n_bad++; $display("FAIL rm_first_out: got valid=%b pc=%h want valid=1 pc=00000000", fi.if_valid, fi.if_pc);
      end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] want [4];
      int idx = 0;
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000; want[3] = 32'h0000_0004;
      tick(); rst_w = 1'b0; settle();
      n_cmp++; if (fw.imem_a !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_first_a: got %h want fffffff8", fw.imem_a); end
      for (int i = 0; i < 12 && idx < 4; i++) begin
         tick(); settle();
         if (fw.if_valid) begin
            n_cmp++; if (fw.if_pc !== want[idx]) begin n_bad++; $display("FAIL wrap_pc: got %h want %h", fw.if_pc, want[idx]); end
            n_cmp++; if (fw.if_instr !== (want[idx] >> 2)) begin
               n_bad++; $display("FAIL wrap_instr: got %h want %h", fw.if_instr, want[idx] >> 2);
            end
            idx++;
         end
      end
      n_cmp++; if (idx != 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", idx); end
   endtask

`ifdef IF_PERF_EN
   task automatic test_perf();
      int stalls = 0;
      int acc = 0;
      tick(); rst = 1'b1; fi.if_ready = 1'b0; settle();
      tick(); rst = 1'b0; settle();
      n_cmp++; if (perf_fetch_cnt !== 32'd0) begin n_bad++; $display("FAIL perf_fetch_rst: got %0d want 0", perf_fetch_cnt); end
      n_cmp++; if (perf_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL perf_stall_rst: got %0d want 0", perf_stall_cnt); end
      for (int i = 0; i < 40 && acc < 10; i++) begin
         tick(); fi.if_ready = (stalls >= 3); settle();
         if (fi.if_valid && !fi.if_ready) stalls++;
         else if (fi.if_valid && fi.if_ready) acc++;
      end
      tick(); fi.if_ready = 1'b0; settle();
      n_cmp++; if (acc != 10) begin n_bad++; $display("FAIL perf_accepts: got %0d want 10", acc); end
      n_cmp++; if (perf_fetch_cnt !== 32'd10) begin n_bad++; $display("FAIL perf_fetch: got %0d want 10", perf_fetch_cnt); end
      n_cmp++; if (perf_stall_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_startup();
      test_backpressure();
      test_redirect_full();
      test_redirect_pending();
      test_back_to_back();
      test_reset_midstream();
      test_pc_wrap();
`ifdef IF_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
